// File: rtl/par_shift_pkg.sv
// Shared mode codes and FSM state type for the universal shift register.
package par_shift_pkg;

  localparam logic [2:0] MODE_SHL = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/par_shift_step.sv
// One STEP-bit shift/rotate of q in the selected mode; purely combinational.
module par_shift_step
  import par_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [STEP-1:0]  shiftin,
  output logic [WIDTH-1:0] next_q,
  output logic [STEP-1:0]  shiftout
);

  always_comb begin
    next_q   = q;
    shiftout = '0;
    case (mode)
      MODE_SHL: begin
        next_q   = {q[WIDTH-STEP-1:0], shiftin};
        shiftout = q[WIDTH-1 -: STEP];
      end
      MODE_SHR: begin
        next_q   = {shiftin, q[WIDTH-1:STEP]};
        shiftout = q[STEP-1:0];
      end
      MODE_ROL: begin
        next_q   = {q[WIDTH-STEP-1:0], q[WIDTH-1 -: STEP]};
        shiftout = q[WIDTH-1 -: STEP];
      end
      MODE_ROR: begin
        next_q   = {q[STEP-1:0], q[WIDTH-1:STEP]};
        shiftout = q[STEP-1:0];
      end
      MODE_ASR: begin
        next_q   = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};
        shiftout = q[STEP-1:0];
      end
      // reserved codes hold q and drive no shiftout
      default: begin
        next_q   = q;
        shiftout = '0;
      end
    endcase
  end

endmodule

// File: rtl/par_univ_shift_reg.sv
// Universal shift register with counted multi-step shift/rotate engine.
// Optional registered parity output enabled by `define PAR_USR_PARITY_EN.
module par_univ_shift_reg
  import par_shift_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      STEP        = 1,
  parameter logic [WIDTH-1:0] LOAD_SVALUE = '1,
  parameter int unsigned      CNT_W       = $clog2(WIDTH/STEP+1)
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             enable,
  input  logic             sset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [STEP-1:0]  shiftin,
  output logic [WIDTH-1:0] q,
  output logic [STEP-1:0]  shiftout,
  output logic             busy,
  output logic             done
`ifdef PAR_USR_PARITY_EN
  ,output logic            parity
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] step_q;
  logic [2:0]       mode_act;

  // latched mode governs while shifting, the live input otherwise
  assign mode_act = (state_q == ST_SHIFT) ? mode_q : mode;

  par_shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .q        (q_q),
    .mode     (mode_act),
    .shiftin  (shiftin),
    .next_q   (step_q),
    .shiftout (shiftout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    q_d     = q_q;
    if (sset) begin
      q_d     = LOAD_SVALUE;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (load) begin
      q_d     = data;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d  = mode;
            cnt_d   = amount;
            state_d = (amount != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          q_d   = step_q;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      q_q     <= '0;
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
    end
  end

`ifdef PAR_USR_PARITY_EN
  always_ff @(posedge clock) begin
    if (sclr)        parity <= 1'b0;
    else if (enable) parity <= ^q_d;
  end
`endif

  assign q    = q_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_par_univ_shift_reg.sv
// Randomised + directed bench for par_univ_shift_reg (STEP=1 and STEP=2 instances).
module tb_par_univ_shift_reg;

  logic       clock = 1'b0;
  logic       sclr, enable, sset, load, start;
  logic [7:0] data;
  logic [2:0] mode;
  logic [3:0] amount;
  logic [1:0] shiftin;

  logic [7:0] q0, q1;
  logic [0:0] so0;
  logic [1:0] so1;
  logic       busy0, busy1, done0, done1;
`ifdef PAR_USR_PARITY_EN
  logic       parity0, parity1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clock = ~clock;

  par_univ_shift_reg #(.WIDTH(8), .STEP(1)) dut0 (
    .clock(clock), .sclr(sclr), .enable(enable), .sset(sset), .load(load),
    .data(data), .start(start), .mode(mode), .amount(amount),
    .shiftin(shiftin[0:0]), .q(q0), .shiftout(so0), .busy(busy0), .done(done0)
`ifdef PAR_USR_PARITY_EN
    , .parity(parity0)
`endif
  );

  par_univ_shift_reg #(.WIDTH(8), .STEP(2)) dut1 (
    .clock(clock), .sclr(sclr), .enable(enable), .sset(sset), .load(load),
    .data(data), .start(start), .mode(mode), .amount(amount[2:0]),
    .shiftin(shiftin), .q(q1), .shiftout(so1), .busy(busy1), .done(done1)
`ifdef PAR_USR_PARITY_EN
    , .parity(parity1)
`endif
  );

  // Reference model: register value, steps remaining, busy/done flags.
  logic [7:0] m_q    [2];
  logic [2:0] m_mode [2];
  int         m_rem  [2];
  bit         m_busy [2];
  bit         m_done [2];

  function automatic logic [7:0] shift_once(logic [7:0] v, logic [2:0] md, int s, int fill);
    int x = int'(v);
    case (md)
      3'd0: x = (x << s) | fill;
      3'd1: x = (x >> s) | (fill << (8 - s));
      3'd2: x = (x << s) | (x >> (8 - s));
      3'd3: x = (x >> s) | (x << (8 - s));
      3'd4: begin
        if (v[7]) x = x | 32'hFFFF_FF00;
        x = x >>> s;
      end
      default: x = int'(v);
    endcase
    return 8'(x);
  endfunction

  function automatic int exp_shiftout(int k);
    logic [2:0] md = m_busy[k] ? m_mode[k] : mode;
    int s = k + 1;
    int v = int'(m_q[k]);
    if (md == 3'd0 || md == 3'd2) return v >> (8 - s);
    if (md == 3'd1 || md == 3'd3 || md == 3'd4) return v & ((1 << s) - 1);
    return 0;
  endfunction

  task automatic model_edge(int k);
    int amt  = (k == 0) ? int'(amount) : int'(amount[2:0]);
    int fill = (k == 0) ? int'(shiftin[0]) : int'(shiftin);
    if (sclr) begin
      m_q[k] = '0; m_rem[k] = 0; m_busy[k] = 0; m_done[k] = 0;
    end else if (enable) begin
      if (sset || load) begin
        m_q[k] = sset ? 8'hFF : data;
        m_busy[k] = 0; m_done[k] = 0; m_rem[k] = 0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_busy[k]) begin
        m_q[k] = shift_once(m_q[k], m_mode[k], k + 1, fill);
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_busy[k] = 0; m_done[k] = 1;
        end
      end else if (start) begin
        m_mode[k] = mode;
        m_rem[k]  = amt;
        if (amt == 0) m_done[k] = 1;
        else          m_busy[k] = 1;
      end
    end
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) model_edge(k);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("q0",     32'(q0),    32'(m_q[0]));
      chk("so0",    32'(so0),   32'(exp_shiftout(0)));
      chk("busy0",  32'(busy0), 32'(m_busy[0]));
      chk("done0",  32'(done0), 32'(m_done[0]));
      chk("q1",     32'(q1),    32'(m_q[1]));
      chk("so1",    32'(so1),   32'(exp_shiftout(1)));
      chk("busy1",  32'(busy1), 32'(m_busy[1]));
      chk("done1",  32'(done1), 32'(m_done[1]));
`ifdef PAR_USR_PARITY_EN
      chk("par0",   32'(parity0), 32'(^m_q[0]));
      chk("par1",   32'(parity1), 32'(^m_q[1]));
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    sclr = 0; enable = 1; sset = 0; load = 0; start = 0;
  endtask

  task automatic do_load(logic [7:0] d);
    load = 1; data = d; tick(); load = 0;
  endtask

  task automatic do_start(logic [2:0] md, logic [3:0] amt, logic [1:0] si);
    start = 1; mode = md; amount = amt; shiftin = si; tick(); start = 0;
  endtask

  int busy_cycles;
  bit seen_done;

  initial begin
    sclr = 1; enable = 1; sset = 0; load = 0; start = 0;
    data = '0; mode = '0; amount = '0; shiftin = '0;

    // 1: reset and sset
    tick(); check_en = 1'b1; tick();
    chk("t1_rst_q",    32'(q0), 32'h00);
    chk("t1_rst_busy", 32'(busy0), 32'h0);
    chk("t1_rst_done", 32'(done0), 32'h0);
    sclr = 0; sset = 1; tick(); sset = 0;
    chk("t1_sset_q", 32'(q0), 32'hFF);
    do_load(8'h12);
    enable = 0; sset = 1; tick(); sset = 0; enable = 1;
    chk("t1_sset_gated", 32'(q0), 32'h12);

    // 2: counted SHL
    do_load(8'b0101_1101);
    do_start(3'b000, 4'd3, 2'b01);
    chk("t2_so_pre_t1", 32'(so0), 32'h0);
    chk("t2_busy_t0",   32'(busy0), 32'h1);
    tick(); chk("t2_so_pre_t2", 32'(so0), 32'h1);
    tick(); chk("t2_so_pre_t3", 32'(so0), 32'h0);
    tick();
    chk("t2_q",      32'(q0), 32'hEF);
    chk("t2_model",  32'(m_q[0]), 32'hEF);
    chk("t2_done",   32'(done0), 32'h1);
    chk("t2_busy",   32'(busy0), 32'h0);
    tick(); chk("t2_done_pulse", 32'(done0), 32'h0);

    // 3: ASR, STEP=2 instance
    do_load(8'h90);
    do_start(3'b100, 4'd2, 2'b00);
    tick(); chk("t3_not_done_yet", 32'(done1), 32'h0);
    tick();
    chk("t3_q1",    32'(q1), 32'hF9);
    chk("t3_model", 32'(m_q[1]), 32'hF9);
    chk("t3_done1", 32'(done1), 32'h1);
    chk("t3_q0",    32'(q0), 32'hE4);
    tick();

    // 4: ROR full turn with a 2-cycle stall
    do_load(8'hA5);
    do_start(3'b011, 4'd8, 2'b00);
    busy_cycles = 0; seen_done = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy0) busy_cycles++;
      if (done0) begin seen_done = 1; break; end
      enable = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      tick();
    end
    enable = 1;
    chk("t4_done_seen", 32'(seen_done), 32'h1);
    chk("t4_q",         32'(q0), 32'hA5);
    chk("t4_busy_len",  32'(busy_cycles), 32'd10);
    tick();

    // 5: abort by load, then amount = 0
    do_start(3'b000, 4'd5, 2'b11);
    tick(); tick();
    do_load(8'h3C);
    chk("t5_abort_q",    32'(q0), 32'h3C);
    chk("t5_abort_busy", 32'(busy0), 32'h0);
    chk("t5_abort_done", 32'(done0), 32'h0);
    tick(); chk("t5_no_done", 32'(done0), 32'h0);
    do_start(3'b000, 4'd0, 2'b11);
    chk("t5_amt0_done", 32'(done0), 32'h1);
    chk("t5_amt0_busy", 32'(busy0), 32'h0);
    chk("t5_amt0_q",    32'(q0), 32'h3C);
    tick(); chk("t5_amt0_pulse", 32'(done0), 32'h0);

    // 6: sclr mid-operation
    do_start(3'b010, 4'd5, 2'b00);
    tick(); tick();
    sclr = 1; tick(); sclr = 0;
    chk("t6_q",    32'(q0), 32'h00);
    chk("t6_busy", 32'(busy0), 32'h0);
    chk("t6_done", 32'(done0), 32'h0);
`ifdef PAR_USR_PARITY_EN
    chk("t6_par0", 32'(parity0), 32'h0);
`endif
    tick(); chk("t6_no_done", 32'(done0), 32'h0);
    do_load(8'h07);
    chk("t6_q07", 32'(q0), 32'h07);
`ifdef PAR_USR_PARITY_EN
    chk("t6_par1", 32'(parity0), 32'h1);
`endif

    // Random traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      sclr    = ($urandom_range(0, 79) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      sset    = ($urandom_range(0, 39) == 0);
      load    = ($urandom_range(0, 19) == 0);
      start   = ($urandom_range(0, 3) == 0);
      mode    = 3'($urandom_range(0, 7));
      amount  = 4'($urandom_range(0, 15));
      shiftin = 2'($urandom_range(0, 3));
      data    = 8'($urandom_range(0, 255));
      tick();
    end
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
